// File: rtl/sim_ctrl_arbiter.sv
// Round-robin arbiter that lets several hosts share the simulator control device.
// It returns each 1-cycle device response to the host that issued the request, and it gates writes once a halt has been requested.
module sim_ctrl_arbiter #(
    parameter int unsigned NumReq      = 2,
    parameter logic [7:0]  CtrlWordIdx = 8'h2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      host_req_i,
    input  logic [NumReq-1:0]      host_we_i,
    input  logic [4*NumReq-1:0]    host_be_i,
    input  logic [32*NumReq-1:0]   host_addr_i,
    input  logic [32*NumReq-1:0]   host_wdata_i,
    output logic [NumReq-1:0]      host_gnt_o,
    output logic [NumReq-1:0]      host_rvalid_o,
    output logic [32*NumReq-1:0]   host_rdata_o,
    output logic                   dev_req_o,
    output logic                   dev_we_o,
    output logic [3:0]             dev_be_o,
    output logic [31:0]            dev_addr_o,
    output logic [31:0]            dev_wdata_o,
    input  logic                   dev_rvalid_i,
    input  logic [31:0]            dev_rdata_i,
    output logic                   halted_o,
    output logic                   err_o
);
    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned PosW = IdxW + 1;

    typedef enum logic {ST_RUN, ST_HALTED} state_e;

    state_e          state_reg, state_next;
    logic [IdxW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IdxW-1:0] owner_reg, owner_next;
    logic            pending_reg, pending_next;
    logic            err_reg, err_next;

    logic            gnt_any;
    logic [IdxW-1:0] gnt_idx;
    logic [PosW-1:0] pos;
    logic            we_allow;
    logic            halt_hit;
    logic            rsp_valid;

    logic [3:0]      be_arr    [NumReq];
    logic [31:0]     addr_arr  [NumReq];
    logic [31:0]     wdata_arr [NumReq];

    genvar gi;
    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_host
            assign be_arr[gi]    = host_be_i[4*gi +: 4];
            assign addr_arr[gi]  = host_addr_i[32*gi +: 32];
            assign wdata_arr[gi] = host_wdata_i[32*gi +: 32];

            assign host_gnt_o[gi]    = gnt_any && (gnt_idx == IdxW'(gi));
            assign host_rvalid_o[gi] = rsp_valid && (owner_reg == IdxW'(gi));
            assign host_rdata_o[32*gi +: 32] = (owner_reg == IdxW'(gi)) ? dev_rdata_i : 32'h0;
        end
    endgenerate

    // Scan from rr_ptr upward with wrap-around; the first requester found wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        pos     = '0;
        for (int off = 0; off < NumReq; off++) begin
            pos = {1'b0, rr_ptr_reg} + PosW'(off);
            if (pos >= PosW'(NumReq)) begin
                pos = pos - PosW'(NumReq);
            end
            if (!gnt_any && host_req_i[pos[IdxW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = pos[IdxW-1:0];
            end
        end
        if (rst_i) begin
            gnt_any = 1'b0;
        end
    end

    assign dev_req_o   = gnt_any;
    assign dev_we_o    = gnt_any && host_we_i[gnt_idx] && we_allow;
    assign dev_be_o    = gnt_any ? be_arr[gnt_idx]    : 4'h0;
    assign dev_addr_o  = gnt_any ? addr_arr[gnt_idx]  : 32'h0;
    assign dev_wdata_o = gnt_any ? wdata_arr[gnt_idx] : 32'h0;

    assign halt_hit = gnt_any && host_we_i[gnt_idx]
                   && (addr_arr[gnt_idx][9:2] == CtrlWordIdx)
                   && be_arr[gnt_idx][0] && wdata_arr[gnt_idx][0];

    // A response arriving while reset is held belongs to a dropped transaction.
    assign rsp_valid = dev_rvalid_i && pending_reg && !rst_i;
    assign err_o     = err_reg;

    always_comb begin
        rr_ptr_next  = rr_ptr_reg;
        owner_next   = owner_reg;
        pending_next = gnt_any;
        err_next     = err_reg | (pending_reg ^ dev_rvalid_i);
        if (gnt_any) begin
            owner_next = gnt_idx;
            if (gnt_idx == IdxW'(NumReq - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg  <= '0;
            owner_reg   <= '0;
            pending_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            rr_ptr_reg  <= rr_ptr_next;
            owner_reg   <= owner_next;
            pending_reg <= pending_next;
            err_reg     <= err_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:    if (halt_hit) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
        endcase
    end

    always_comb begin
        halted_o = (state_reg == ST_HALTED);
        we_allow = (state_reg == ST_RUN);
    end

endmodule

// File: tb/tb_sim_ctrl_arbiter.sv
// Scoreboard bench for sim_ctrl_arbiter: a device model answers every request one cycle later.
// Expected responses are queued at grant time and then checked when host_rvalid_o fires.
module tb_sim_ctrl_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  host_req_i = '0;
    logic [1:0]  host_we_i = '0;
    logic [7:0]  host_be_i = '0;
    logic [63:0] host_addr_i = '0;
    logic [63:0] host_wdata_i = '0;
    logic [1:0]  host_gnt_o;
    logic [1:0]  host_rvalid_o;
    logic [63:0] host_rdata_o;
    logic        dev_req_o, dev_we_o;
    logic [3:0]  dev_be_o;
    logic [31:0] dev_addr_o, dev_wdata_o;
    logic        dev_rvalid_i = 1'b0;
    logic [31:0] dev_rdata_i = '0;
    logic        halted_o, err_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int          host;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t sb[$];

    logic        dev_mute = 1'b0;
    logic        dev_spurious = 1'b0;
    logic        req_q = 1'b0;
    logic [31:0] addr_q = '0;

    sim_ctrl_arbiter #(.NumReq(2), .CtrlWordIdx(8'h2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_be_i(host_be_i),
        .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
        .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
        .dev_req_o(dev_req_o), .dev_we_o(dev_we_o), .dev_be_o(dev_be_o),
        .dev_addr_o(dev_addr_o), .dev_wdata_o(dev_wdata_o),
        .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
        .halted_o(halted_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Device model: answer a request seen in one cycle during the next cycle.
    always @(negedge clk_i) begin
        req_q  = dev_req_o;
        addr_q = dev_addr_o;
    end
    always @(posedge clk_i) begin
        #1;
        dev_rvalid_i = (req_q && !dev_mute) || dev_spurious;
        dev_rdata_i  = req_q ? (32'hD000_0000 ^ addr_q) : 32'h0;
    end

    // Response scoreboard
    always @(negedge clk_i) begin
        rsp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_missing: host %0d got no rvalid, required one in cycle %0d", sb[0].host, sb[0].due);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            vectors++;
            if (host_rvalid_o !== (2'b01 << e.host)) begin
                miscompares++;
                $display("FAIL rsp_rvalid: got %b, required %b", host_rvalid_o, 2'b01 << e.host);
            end
            vectors++;
            if (host_rdata_o[32*e.host +: 32] !== e.data) begin
                miscompares++;
                $display("FAIL rsp_rdata: host %0d got %h, required %h", e.host, host_rdata_o[32*e.host +: 32], e.data);
            end
            vectors++;
            if (host_rdata_o[32*(1-e.host) +: 32] !== 32'h0) begin
                miscompares++;
                $display("FAIL rsp_rdata_other: host %0d got %h, required 0", 1 - e.host, host_rdata_o[32*(1-e.host) +: 32]);
            end
            $display("rsp cycle %0d host %0d data %h", cyc, e.host, e.data);
        end else begin
            vectors++;
            if (host_rvalid_o !== 2'b00) begin
                miscompares++;
                $display("FAIL rsp_spurious: cycle %0d got rvalid %b, required 00", cyc, host_rvalid_o);
            end
        end
    end

    function automatic void push_rsp(input int h, input logic [31:0] a);
        rsp_t e;
        e.host = h;
        e.data = 32'hD000_0000 ^ a;
        e.due  = cyc + 1;
        sb.push_back(e);
    endfunction

    // Apply one cycle of host inputs just after the clock edge. Return at the following falling edge.
    task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [7:0] be,
                         input logic [63:0] addr, input logic [63:0] wdata);
        @(posedge clk_i);
        #1;
        host_req_i   = req;
        host_we_i    = we;
        host_be_i    = be;
        host_addr_i  = addr;
        host_wdata_i = wdata;
        @(negedge clk_i);
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 8'h00, 64'h0, 64'h0);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        host_req_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        host_req_i = 2'b11;
        host_we_i  = 2'b11;
        @(negedge clk_i);
        vectors++;
        if (host_gnt_o !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b, required 00", host_gnt_o); end
        vectors++;
        if (dev_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_dev_req: got %b, required 0", dev_req_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        vectors++;
        if (halted_o !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b, required 0", halted_o); end
        vectors++;
        if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b, required 0", err_o); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        host_req_i = 2'b00;
        host_we_i  = 2'b00;
        @(negedge clk_i);
        $display("txn reset done");
    endtask

    task automatic test_alternate();
        logic [1:0] exp_gnt;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b00, 8'hFF, {32'h0000_0200, 32'h0000_0100}, 64'h0);
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            vectors++;
            if (host_gnt_o !== exp_gnt) begin miscompares++; $display("FAIL alt_gnt%0d: got %b, required %b", i, host_gnt_o, exp_gnt); end
            vectors++;
            if (dev_addr_o !== ((i % 2 == 0) ? 32'h100 : 32'h200)) begin
                miscompares++; $display("FAIL alt_addr%0d: got %h", i, dev_addr_o);
            end
            push_rsp(i % 2, (i % 2 == 0) ? 32'h100 : 32'h200);
            $display("txn alternate grant %b", exp_gnt);
        end
        idle();
    endtask

    task automatic test_single_host();
        drive(2'b10, 2'b10, 8'h10, {32'h0000_0000, 32'h0}, {32'h0000_0041, 32'h0});
        vectors++;
        if (host_gnt_o !== 2'b10) begin miscompares++; $display("FAIL single_gnt: got %b, required 10", host_gnt_o); end
        vectors++;
        if (dev_we_o !== 1'b1) begin miscompares++; $display("FAIL single_we: got %b, required 1", dev_we_o); end
        vectors++;
        if (dev_wdata_o !== 32'h41) begin miscompares++; $display("FAIL single_wdata: got %h, required 00000041", dev_wdata_o); end
        push_rsp(1, 32'h0);
        $display("txn single host1 write 41");
        // After granting host 1 the pointer wraps to 0, so host 0 wins a tie.
        drive(2'b11, 2'b00, 8'hFF, {32'h0000_0300, 32'h0000_0304}, 64'h0);
        vectors++;
        if (host_gnt_o !== 2'b01) begin miscompares++; $display("FAIL single_rr_wrap: got %b, required 01", host_gnt_o); end
        push_rsp(0, 32'h304);
        idle();
    endtask

    task automatic test_halt();
        drive(2'b01, 2'b01, 8'h01, {32'h0, 32'h0000_0008}, {32'h0, 32'h0000_0001});
        vectors++;
        if (host_gnt_o !== 2'b01 || dev_we_o !== 1'b1) begin
            miscompares++; $display("FAIL halt_write: got gnt %b we %b, required 01 1", host_gnt_o, dev_we_o);
        end
        vectors++;
        if (halted_o !== 1'b0) begin miscompares++; $display("FAIL halt_early: got %b, required 0", halted_o); end
        push_rsp(0, 32'h8);
        idle();
        vectors++;
        if (halted_o !== 1'b1) begin miscompares++; $display("FAIL halt_set: got %b, required 1", halted_o); end
        drive(2'b10, 2'b10, 8'h10, {32'h0, 32'h0}, {32'h0000_0042, 32'h0});
        vectors++;
        if (dev_req_o !== 1'b1 || dev_we_o !== 1'b0 || host_gnt_o !== 2'b10) begin
            miscompares++; $display("FAIL halt_gate: got req %b we %b gnt %b, required 1 0 10", dev_req_o, dev_we_o, host_gnt_o);
        end
        push_rsp(1, 32'h0);
        drive(2'b01, 2'b01, 8'h01, {32'h0, 32'h0000_0008}, {32'h0, 32'h0000_0001});
        vectors++;
        if (dev_we_o !== 1'b0) begin miscompares++; $display("FAIL halt_second: got we %b, required 0", dev_we_o); end
        push_rsp(0, 32'h8);
        idle();
        vectors++;
        if (halted_o !== 1'b1) begin miscompares++; $display("FAIL halt_sticky: got %b, required 1", halted_o); end
        $display("txn halt sequence done");
    endtask

    task automatic test_reset_inflight();
        drive(2'b01, 2'b00, 8'hFF, {32'h0, 32'h0000_0010}, 64'h0);
        vectors++;
        if (host_gnt_o !== 2'b01) begin miscompares++; $display("FAIL inflight_gnt: got %b, required 01", host_gnt_o); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        host_req_i = 2'b00;
        @(negedge clk_i);
        vectors++;
        if (dev_rvalid_i !== 1'b1) begin miscompares++; $display("FAIL inflight_devrsp: got %b, required 1", dev_rvalid_i); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (err_o !== 1'b0 || halted_o !== 1'b0) begin
            miscompares++; $display("FAIL inflight_flags: got err %b halted %b, required 0 0", err_o, halted_o);
        end
        drive(2'b11, 2'b00, 8'hFF, {32'h0000_0020, 32'h0000_0024}, 64'h0);
        vectors++;
        if (host_gnt_o !== 2'b01) begin miscompares++; $display("FAIL inflight_next_gnt: got %b, required 01", host_gnt_o); end
        push_rsp(0, 32'h24);
        idle();
        $display("txn reset in flight done");
    endtask

    task automatic test_no_halt();
        do_reset();
        drive(2'b01, 2'b01, 8'h00, {32'h0, 32'h0000_0008}, {32'h0, 32'h0000_0001});
        vectors++;
        if (dev_we_o !== 1'b1) begin miscompares++; $display("FAIL nohalt_we: got %b, required 1", dev_we_o); end
        push_rsp(0, 32'h8);
        drive(2'b01, 2'b01, 8'h01, {32'h0, 32'h0000_0008}, {32'h0, 32'h0000_0002});
        push_rsp(0, 32'h8);
        idle();
        vectors++;
        if (halted_o !== 1'b0) begin miscompares++; $display("FAIL nohalt_halted: got %b, required 0", halted_o); end
        $display("txn no-halt writes done");
    endtask

    task automatic test_err();
        do_reset();
        dev_mute = 1'b1;
        drive(2'b01, 2'b00, 8'hFF, {32'h0, 32'h0000_0040}, 64'h0);
        idle();
        dev_mute = 1'b0;
        idle();
        vectors++;
        if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_missing_rsp: got %b, required 1", err_o); end
        idle();
        vectors++;
        if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b, required 1", err_o); end
        do_reset();
        vectors++;
        if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_cleared: got %b, required 0", err_o); end
        dev_spurious = 1'b1;
        idle();
        dev_spurious = 1'b0;
        idle();
        idle();
        vectors++;
        if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_spurious: got %b, required 1", err_o); end
        $display("txn error cases done");
    endtask

    task automatic test_random();
        logic [1:0]  r, w, exp_gnt;
        logic [31:0] a0, a1, d0, d1;
        int          rr, idx, gidx;
        bit          found;
        do_reset();
        rr = 0;
        for (int i = 0; i < 24; i++) begin
            r  = 2'($urandom_range(0, 3));
            w  = 2'($urandom_range(0, 3));
            a0 = ($urandom & 32'hFFFF_FC00) | 32'h100;
            a1 = ($urandom & 32'hFFFF_FC00) | 32'h100;
            d0 = $urandom;
            d1 = $urandom;
            drive(r, w, 8'hFF, {a1, a0}, {d1, d0});
            found = 1'b0;
            gidx  = 0;
            for (int off = 0; off < 2; off++) begin
                idx = (rr + off) % 2;
                if (!found && r[idx]) begin found = 1'b1; gidx = idx; end
            end
            exp_gnt = found ? (2'b01 << gidx) : 2'b00;
            vectors++;
            if (host_gnt_o !== exp_gnt) begin miscompares++; $display("FAIL rand_gnt%0d: got %b, required %b", i, host_gnt_o, exp_gnt); end
            if (found) begin
                vectors++;
                if (dev_addr_o !== (gidx == 0 ? a0 : a1) || dev_we_o !== w[gidx]) begin
                    miscompares++; $display("FAIL rand_fwd%0d: got addr %h we %b", i, dev_addr_o, dev_we_o);
                end
                push_rsp(gidx, gidx == 0 ? a0 : a1);
                rr = (gidx + 1) % 2;
            end
            $display("txn random %0d req %b gnt %b", i, r, exp_gnt);
        end
        idle();
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        test_reset();
        test_alternate();
        test_single_host();
        test_halt();
        test_reset_inflight();
        test_no_halt();
        test_err();
        test_random();
        idle();
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL sb_drain: %0d responses never arrived", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
